mem_1rw_arbiter: RTL and testbench
==================================

// Module: mem_1rw_arbiter
// PURPOSE
//  Shares one single-port (1RW) SRAM macro wrapper between two requesters (port 0, port 1).
//  Round-robin arbitration grants at most one access per cycle and drives the macro's RW0_* pins directly.
//  Each port's read data is returned through a one-entry response register with valid/ready backpressure.
//  Writes are posted and produce no response.
// PARAMETERS
//  DEPTH   48  number of words in the attached SRAM; addresses >= DEPTH are out of range
//  WIDTH   64  data width in bits
//  ADDR_W  6   address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk            in   1       single clock; also drives mem_clk
//  rst_n          in   1       synchronous reset, active-low
//  req_valid[p]   in   1       port p (p=0,1) request valid
//  req_ready[p]   out  1       port p request accepted this cycle
//  req_write[p]   in   1       1 = write, 0 = read
//  req_addr[p]    in   ADDR_W  word address
//  req_wdata[p]   in   WIDTH   write data
//  resp_valid[p]  out  1       port p read data valid
//  resp_ready[p]  in   1       port p consumer accepts read data
//  resp_rdata[p]  out  WIDTH   read data
//  mem_clk        out  1       = clk
//  mem_en         out  1       SRAM access enable (active-high; the wrapper inverts it to CEN)
//  mem_wmode      out  1       1 = write
//  mem_addr       out  ADDR_W  SRAM address
//  mem_wdata      out  WIDTH   SRAM write data
//  mem_rdata      in   WIDTH   SRAM Q; valid in the cycle after a read enable
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - clears resp_valid[1:0], inflight[1:0] and rr_ptr (port 0 gets priority first);
//   - resp_rdata is cleared to 0;
//   - while rst_n=0, req_ready=0 and mem_en=0 combinationally;
//   - any read in flight is discarded and never returned.
//  Eligibility: elig[p] = req_valid[p] & (req_write[p] | slot_ok[p]),
//   where slot_ok[p] = ~inflight[p] & (~resp_valid[p] | resp_ready[p]).
//  Grant:
//   - exactly one eligible port -> that port is granted;
//   - both eligible -> port rr_ptr is granted;
//   - on every grant, rr_ptr <= ~granted port;
//   - no grant -> rr_ptr holds.
//  req_ready[p] = grant[p]; it is combinational from req_valid and req_write (no valid->ready loop upstream).
//  Accepted request in cycle T:
//   - mem_en=1 in T only if req_addr < DEPTH;
//   - mem_wmode = req_write; mem_addr and mem_wdata come from the granted port;
//   - when mem_en=0, mem_wmode/mem_addr/mem_wdata are driven 0.
//  Out-of-range write: accepted and dropped (mem_en stays 0).
//  Out-of-range read: accepted; returns all-zero data with normal timing.
//  Read timing (request accepted in T):
//   - inflight[p]=1 during T+1;
//   - at the end of T+1, resp_rdata[p] <= mem_rdata (or 0 if out of range) and resp_valid[p] <= 1;
//   - resp_valid[p] is high from T+2; minimum latency is 2 cycles.
//  Response handshake: resp_valid[p] & resp_ready[p] at an edge clears resp_valid[p], unless a new capture
//   lands at the same edge (the new capture wins and resp_valid stays 1).
//  Throughput:
//   - one access per cycle in total;
//   - back-to-back reads on the same port are never granted (inflight blocks them);
//   - the other port, or a write, may use the gap.
//  Reads and writes on the same port complete in acceptance order.
//   - A write accepted in T is visible to any read accepted in T+1 or later.
//  resp_rdata[p] holds stable while resp_valid[p]=1 and resp_ready[p]=0.
// TESTING
//  1. Reset, then port 0 writes addr 5 = 0xDEAD_BEEF_0000_0001, then reads addr 5 with resp_ready=1
//     -> resp_valid[0] high exactly 2 cycles after read accept, resp_rdata[0]=0xDEAD_BEEF_0000_0001.
//  2. Both ports hold valid writes continuously for 6 cycles
//     -> grants alternate 0,1,0,1,0,1; mem_en=1 every cycle.
//  3. Port 1 read of addr 47 with resp_ready[1]=0 for 5 cycles
//     -> resp_valid[1] stays 1 and data stays stable; a second port-1 read has req_ready[1]=0 until resp_ready[1]=1;
//     meanwhile port-0 writes are still granted.
//  4. Port 0 write to addr 48 then read addr 48
//     -> mem_en=0 on both accesses; the read returns 0 after 2 cycles; addr 0 contents unchanged.
//  5. Drop rst_n for 1 cycle while a port-0 read is in flight
//     -> resp_valid[0] never asserts for that read; rr_ptr=0; req_ready=0 during reset.
//  6. Port 0 holds a pending response and its consumer fires resp_ready in the same cycle a new read is granted
//     -> the new read is accepted; after 2 cycles the new data is returned with no lost or duplicated response.

Source files
------------

// File: rtl/mem_1rw_arbiter_if.sv
// Request/response bundle for the two requesters sharing a 1RW SRAM.
// Index p of each packed vector belongs to port p.
interface mem_1rw_arbiter_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][WIDTH-1:0]  req_wdata;
    logic [1:0]             resp_valid;
    logic [1:0]             resp_ready;
    logic [1:0][WIDTH-1:0]  resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_1rw_arbiter.sv
// Round-robin sharing of one 1RW SRAM between two ports,
// with a one-entry read response register per port.
module mem_1rw_arbiter #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_1rw_arbiter_if.slave  bus,
    output logic              mem_clk,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]            inflight;
    logic [1:0]            oor_q;
    logic [1:0]            resp_valid_q;
    logic [1:0][WIDTH-1:0] rdata_q;
    logic                  rr_ptr;

    logic [1:0]        slot_ok;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              sel;
    logic              acc;
    logic [ADDR_W-1:0] a_addr;
    logic              a_write;
    logic              in_range;

    assign mem_clk = clk;

    // A read needs a free response slot; writes never do.
    assign slot_ok = ~inflight & (~resp_valid_q | bus.resp_ready);
    assign elig    = rst_n ? (bus.req_valid & (bus.req_write | slot_ok))
                           : 2'b00;

    always_comb begin
        grant = 2'b00;
        unique case (elig)
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = elig;
        endcase
    end

    assign sel      = grant[1];
    assign acc      = |grant;
    assign a_addr   = bus.req_addr[sel];
    assign a_write  = bus.req_write[sel];
    assign in_range = {1'b0, a_addr} < DEPTH_L;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc && in_range) begin
            mem_en    = 1'b1;
            mem_wmode = a_write;
            mem_addr  = a_addr;
            mem_wdata = bus.req_wdata[sel];
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight     <= '0;
            oor_q        <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            rr_ptr       <= 1'b0;
        end else begin
            if (acc) begin
                rr_ptr <= ~sel;
            end
            for (int p = 0; p < 2; p++) begin
                inflight[p] <= grant[p] & ~bus.req_write[p];
                oor_q[p]    <= ~in_range;
                // A capture at the same edge as a consume keeps valid high.
                if (inflight[p]) begin
                    rdata_q[p]      <= oor_q[p] ? '0 : mem_rdata;
                    resp_valid_q[p] <= 1'b1;
                end else if (bus.resp_ready[p]) begin
                    resp_valid_q[p] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_1rw_arbiter.sv
// Directed bench for mem_1rw_arbiter with a behavioural 1RW SRAM.
// Each task drives one scenario and checks against hand-computed values.
module tb_mem_1rw_arbiter;
    localparam int DEPTH  = 48;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 6;

    localparam logic [63:0] V5  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] V47 = 64'h4747_1234_5678_0047;
    localparam logic [63:0] V0  = 64'h0000_0000_CAFE_0000;
    localparam logic [63:0] V7  = 64'h7777_0000_1111_0007;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clk, mem_en, mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_1rw_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mem_1rw_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_clk   (mem_clk),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] sram [64];
    logic [WIDTH-1:0] q;
    assign mem_rdata = q;

    always @(posedge mem_clk) begin
        if (mem_en) begin
            if (mem_wmode) sram[mem_addr] <= mem_wdata;
            else           q <= sram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = 2'b00;
        bus.req_write  = 2'b00;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 2'b00;
    endtask

    task automatic drive(input int p, input logic wr,
                         input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
        bus.req_valid[p] = 1'b1;
        bus.req_write[p] = wr;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        drive(0, 1'b1, 6'd1, 64'h1);
        drive(1, 1'b1, 6'd2, 64'h2);
        settle();
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready got %b exp 00", bus.req_ready);
        end
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_en got %b exp 0", mem_en);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rst_resp_valid got %b exp 00", bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== '0) begin
            errors++;
            $display("FAIL rst_rdata got %h exp 0", bus.resp_rdata);
        end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        drive(0, 1'b1, 6'd5, V5);
        settle();
        checks++;
        if (bus.req_ready !== 2'b01 || mem_en !== 1'b1
            || mem_wmode !== 1'b1 || mem_addr !== 6'd5) begin
            errors++;
            $display("FAIL wr5 got rdy=%b en=%b wm=%b a=%0d exp 01 1 1 5",
                     bus.req_ready, mem_en, mem_wmode, mem_addr);
        end
        tick();
        drive(0, 1'b0, 6'd5, '0);
        bus.resp_ready[0] = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 2'b01 || mem_en !== 1'b1
            || mem_wmode !== 1'b0) begin
            errors++;
            $display("FAIL rd5_accept got rdy=%b en=%b wm=%b exp 01 1 0",
                     bus.req_ready, mem_en, mem_wmode);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd5_early got %b exp 0", bus.resp_valid[0]);
        end
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b1 || bus.resp_rdata[0] !== V5) begin
            errors++;
            $display("FAIL rd5_data got v=%b d=%h exp 1 %h",
                     bus.resp_valid[0], bus.resp_rdata[0], V5);
        end
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd5_consume got %b exp 0", bus.resp_valid[0]);
        end
        idle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [ADDR_W-1:0] exp_a;
        do_reset();
        drive(0, 1'b1, 6'd20, 64'h1000);
        drive(1, 1'b1, 6'd30, 64'h2000);
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 6'd20 : 6'd30;
            settle();
            checks++;
            if (bus.req_ready !== exp_g || mem_en !== 1'b1
                || mem_addr !== exp_a) begin
                errors++;
                $display("FAIL rr_%0d got g=%b en=%b a=%0d exp %b 1 %0d",
                         i, bus.req_ready, mem_en, mem_addr, exp_g, exp_a);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_backpressure();
        idle();
        drive(1, 1'b1, 6'd47, V47);
        settle();
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_wr47 got %b exp 10", bus.req_ready);
        end
        tick();
        drive(1, 1'b0, 6'd47, '0);
        settle();
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_rd47 got %b exp 10", bus.req_ready);
        end
        tick();
        drive(0, 1'b1, 6'd21, 64'h55);
        settle();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_inflight got %b exp 01", bus.req_ready);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (bus.resp_valid[1] !== 1'b1 || bus.resp_rdata[1] !== V47
                || bus.req_ready !== 2'b01) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b d=%h g=%b exp 1 %h 01",
                         i, bus.resp_valid[1], bus.resp_rdata[1],
                         bus.req_ready, V47);
            end
            tick();
        end
        bus.resp_ready[1] = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got %b exp 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.resp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_cleared got %b exp 0", bus.resp_valid[1]);
        end
        tick();
        checks++;
        if (bus.resp_valid[1] !== 1'b1 || bus.resp_rdata[1] !== V47) begin
            errors++;
            $display("FAIL bp_second got v=%b d=%h exp 1 %h",
                     bus.resp_valid[1], bus.resp_rdata[1], V47);
        end
        tick();
        idle();
    endtask

    task automatic test_out_of_range();
        idle();
        drive(0, 1'b1, 6'd0, V0);
        tick();
        drive(0, 1'b1, 6'd48, 64'hFFFF_FFFF_FFFF_FFFF);
        settle();
        checks++;
        if (bus.req_ready !== 2'b01 || mem_en !== 1'b0
            || mem_wmode !== 1'b0 || mem_addr !== '0
            || mem_wdata !== '0) begin
            errors++;
            $display("FAIL oor_wr got g=%b en=%b wm=%b a=%0d d=%h exp 01 0 0 0 0",
                     bus.req_ready, mem_en, mem_wmode, mem_addr, mem_wdata);
        end
        tick();
        drive(0, 1'b0, 6'd48, '0);
        bus.resp_ready[0] = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 2'b01 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_rd got g=%b en=%b exp 01 0",
                     bus.req_ready, mem_en);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b1 || bus.resp_rdata[0] !== '0) begin
            errors++;
            $display("FAIL oor_data got v=%b d=%h exp 1 0",
                     bus.resp_valid[0], bus.resp_rdata[0]);
        end
        drive(0, 1'b0, 6'd0, '0);
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b1 || bus.resp_rdata[0] !== V0) begin
            errors++;
            $display("FAIL oor_addr0 got v=%b d=%h exp 1 %h",
                     bus.resp_valid[0], bus.resp_rdata[0], V0);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_inflight();
        idle();
        drive(0, 1'b0, 6'd5, '0);
        bus.resp_ready[0] = 1'b1;
        tick();
        idle();
        rst_n = 1'b0;
        drive(0, 1'b1, 6'd3, 64'h3);
        drive(1, 1'b1, 6'd4, 64'h4);
        settle();
        checks++;
        if (bus.req_ready !== 2'b00 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rsti_ready got g=%b en=%b exp 00 0",
                     bus.req_ready, mem_en);
        end
        tick();
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.resp_valid !== 2'b00) begin
                errors++;
                $display("FAIL rsti_novalid_%0d got %b exp 00",
                         i, bus.resp_valid);
            end
            tick();
        end
        drive(0, 1'b1, 6'd22, 64'h22);
        drive(1, 1'b1, 6'd23, 64'h23);
        settle();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rsti_rrptr got %b exp 01", bus.req_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        drive(0, 1'b1, 6'd7, V7);
        tick();
        drive(0, 1'b0, 6'd5, '0);
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b1 || bus.resp_rdata[0] !== V5) begin
            errors++;
            $display("FAIL b2b_first got v=%b d=%h exp 1 %h",
                     bus.resp_valid[0], bus.resp_rdata[0], V5);
        end
        drive(0, 1'b0, 6'd7, '0);
        bus.resp_ready[0] = 1'b1;
        settle();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL b2b_accept got %b exp 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %b exp 0", bus.resp_valid[0]);
        end
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b1 || bus.resp_rdata[0] !== V7) begin
            errors++;
            $display("FAIL b2b_second got v=%b d=%h exp 1 %h",
                     bus.resp_valid[0], bus.resp_rdata[0], V7);
        end
        tick();
        checks++;
        if (bus.resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nodup got %b exp 0", bus.resp_valid[0]);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_out_of_range();
        test_reset_inflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
